mips_core: RTL and testbench



---
 rtl/mips_core_pkg.sv | 50 +++++
 rtl/mips_alu.sv | 59 +++++
 rtl/mips_core.sv | 180 ++++++++++++++++++
 tb/tb_mips_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared decode constants and ALU operation encoding for the
// single-cycle MIPS core.
//   - OP_* / FN_*  : opcode and R-type funct field values
//   - alu_op_t     : operation selector handed from decode to mips_alu
//   - REG_COUNT    : architectural register count
//   - is_imm_op()  : recognises the I-type opcodes the core may execute
package mips_core_pkg;

  localparam int REG_COUNT = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_t;

  function automatic logic is_imm_op(input logic [5:0] opcode);
    return (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
           (opcode == OP_ANDI) || (opcode == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_alu.sv
// mips_alu: purely combinational ALU for the single-cycle MIPS core.
// Ports:
//   a, b      : operands (shifts operate on b)
//   shamt     : shift amount for SLL/SRL/SRA
//   alu_op    : operation select (alu_op_t)
//   result    : wrapped result
//   overflow  : signed overflow of ALU_ADD / ALU_SUB; the caller decides
//               whether the instruction actually traps on it (add vs addu)
module mips_alu
  import mips_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  alu_op_t         alu_op,
  output logic [XLEN-1:0] result,
  output logic            overflow
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [XLEN-1:0] sum;
  logic        [XLEN-1:0] diff;

  assign a_s  = a;
  assign b_s  = b;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result   = sum;
        // Operands share a sign but the sum does not.
        overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result   = diff;
        // Operands differ in sign and the difference flips away from a.
        overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = b_s >>> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS R-type core. Each clock with imem_we low
// fetches imem[pc], decodes, executes through mips_alu and writes back at the
// same edge; pc then advances by 4 and wraps at IMEM_DEPTH*4 bytes.
// Optional build macro: MIPS_CORE_IMM_EN adds addi/slti/andi/ori (write rt);
// without it those opcodes retire as NOPs.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   imem_we/waddr/wdata   : program load port; core holds while imem_we=1
//   pc                    : current program counter (byte address)
//   alu_result            : registered result of the last executed instruction
//   wb_valid / wb_addr    : last instruction wrote the register file / last
//                           register written
//   overflow              : last instruction was add/sub(/addi) and overflowed
//   zero                  : alu_result == 0
module mips_core
  import mips_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int XLEN       = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            imem_we,
  input  logic [4:0]      imem_waddr,
  input  logic [31:0]     imem_wdata,
  output logic [31:0]     pc,
  output logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic            overflow,
  output logic            zero
);

  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_WRAP = 32'(IMEM_DEPTH * 4);

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] rf_q [REG_COUNT];

  logic [31:0]     pc_q, pc_d, pc_inc;
  logic [XLEN-1:0] result_q, result_d;
  logic            wb_valid_q, wb_en;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;

  logic            valid, chk_ovf, use_imm;
  alu_op_t         alu_op;
  logic [4:0]      dst;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs_val, rt_val, b_op;
  logic [XLEN-1:0] alu_res;
  logic            alu_ovf;

  // Program memory is deliberately outside the reset domain so a reset
  // restarts the loaded program rather than erasing it.
  always_ff @(posedge clock) begin
    if (imem_we) imem[AW'(imem_waddr)] <= imem_wdata;
  end

  assign instr  = imem[pc_q[AW+1:2]];
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];

  always_comb begin
    valid   = 1'b0;
    chk_ovf = 1'b0;
    use_imm = 1'b0;
    alu_op  = ALU_ADD;
    dst     = rd;
    imm_ext = '0;
    if (opcode == OP_RTYPE) begin
      valid = 1'b1;
      case (funct)
        FN_ADD:  begin alu_op = ALU_ADD; chk_ovf = 1'b1; end
        FN_ADDU: alu_op = ALU_ADD;
        FN_SUB:  begin alu_op = ALU_SUB; chk_ovf = 1'b1; end
        FN_SUBU: alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLTU: alu_op = ALU_SLTU;
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRL:  alu_op = ALU_SRL;
        FN_SRA:  alu_op = ALU_SRA;
        default: valid = 1'b0;
      endcase
    end else if (is_imm_op(opcode)) begin
      dst = rt;
`ifdef MIPS_CORE_IMM_EN
      valid   = 1'b1;
      use_imm = 1'b1;
      case (opcode)
        OP_ADDI: begin
          alu_op  = ALU_ADD;
          chk_ovf = 1'b1;
          imm_ext = {{(XLEN-16){instr[15]}}, instr[15:0]};
        end
        OP_SLTI: begin
          alu_op  = ALU_SLT;
          imm_ext = {{(XLEN-16){instr[15]}}, instr[15:0]};
        end
        OP_ANDI: begin
          alu_op  = ALU_AND;
          imm_ext = {{(XLEN-16){1'b0}}, instr[15:0]};
        end
        default: begin
          alu_op  = ALU_OR;
          imm_ext = {{(XLEN-16){1'b0}}, instr[15:0]};
        end
      endcase
`else
      valid = 1'b0;
`endif
    end
  end

  // r0 is hardwired to zero on the read side.
  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];
  assign b_op   = use_imm ? imm_ext : rt_val;

  mips_alu #(.XLEN(XLEN)) u_alu (
    .a        (rs_val),
    .b        (b_op),
    .shamt    (shamt),
    .alu_op   (alu_op),
    .result   (alu_res),
    .overflow (alu_ovf)
  );

  always_comb begin
    pc_inc    = pc_q + 32'd4;
    pc_d      = (pc_inc >= PC_WRAP) ? '0 : pc_inc;
    ovf_d     = valid && chk_ovf && alu_ovf;
    result_d  = valid ? alu_res : '0;
    // An overflowing add/sub still reports the wrapped sum but never commits.
    wb_en     = valid && !ovf_d && (dst != 5'd0);
    wb_addr_d = wb_en ? dst : wb_addr_q;
    zero_d    = (result_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b1;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= XLEN'(i);
    end else if (!imem_we) begin
      pc_q       <= pc_d;
      result_q   <= result_d;
      wb_valid_q <= wb_en;
      wb_addr_q  <= wb_addr_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      if (wb_en) rf_q[dst] <= result_d;
    end
  end

  assign pc         = pc_q;
  assign alu_result = result_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_mips_core.sv
module tb_mips_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] pc, alu_result;
  logic        wb_valid, overflow, zero;
  logic [4:0]  wb_addr;

  mips_core dut (
    .clock      (clock),
    .reset      (reset),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        wbv;
    logic [4:0]  wba;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model state.
  logic [31:0] m_mem [32];
  logic [31:0] m_rf  [32];
  logic [31:0] m_pc;
  exp_t        m_out;
  logic [31:0] prog  [32];

  localparam longint MAXI = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINI = -64'sh0000_0000_8000_0000;

  logic [5:0] FN_LIST [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
  logic [5:0] IOP_LIST [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_out = '{pc: 32'd0, res: 32'd0, wbv: 1'b0, wba: 5'd0, ovf: 1'b0, zero: 1'b1};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
  endtask

  task automatic model_step(input logic we, input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] instr, a, b, r, simm, zimm;
    int          op, fn, rs, rt, rd, sh, dst;
    longint      s;
    bit          known, ovf, wr;
    if (we) begin
      m_mem[addr] = data;
      exp_q.push_back(m_out);
      return;
    end
    instr = m_mem[m_pc >> 2];
    op = int'(instr[31:26]);
    rs = int'(instr[25:21]);
    rt = int'(instr[20:16]);
    rd = int'(instr[15:11]);
    sh = int'(instr[10:6]);
    fn = int'(instr[5:0]);
    a  = (rs == 0) ? 32'd0 : m_rf[rs];
    b  = (rt == 0) ? 32'd0 : m_rf[rt];
    simm = {{16{instr[15]}}, instr[15:0]};
    zimm = {16'd0, instr[15:0]};
    known = 1'b1;
    ovf   = 1'b0;
    r     = '0;
    dst   = rd;
    s     = 0;
    if (op == 0) begin
      case (fn)
        'h20: begin
          s = longint'($signed(a)) + longint'($signed(b));
          r = s[31:0];
          ovf = (s > MAXI) || (s < MINI);
        end
        'h21: r = a + b;
        'h22: begin
          s = longint'($signed(a)) - longint'($signed(b));
          r = s[31:0];
          ovf = (s > MAXI) || (s < MINI);
        end
        'h23: r = a - b;
        'h24: r = a & b;
        'h25: r = a | b;
        'h26: r = a ^ b;
        'h27: r = ~(a | b);
        'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        'h2B: r = (a < b) ? 32'd1 : 32'd0;
        'h00: r = b << sh;
        'h02: r = b >> sh;
        'h03: r = $signed(b) >>> sh;
        default: known = 1'b0;
      endcase
    end else if (op == 'h08 || op == 'h0A || op == 'h0C || op == 'h0D) begin
`ifdef MIPS_CORE_IMM_EN
      dst = rt;
      case (op)
        'h08: begin
          s = longint'($signed(a)) + longint'($signed(simm));
          r = s[31:0];
          ovf = (s > MAXI) || (s < MINI);
        end
        'h0A: r = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
        'h0C: r = a & zimm;
        default: r = a | zimm;
      endcase
`else
      known = 1'b0;
`endif
    end else begin
      known = 1'b0;
    end
    if (!known) begin
      r   = '0;
      ovf = 1'b0;
      wr  = 1'b0;
    end else begin
      wr = !ovf && (dst != 0);
    end
    if (wr) m_rf[dst] = r;
    m_pc       = (m_pc + 32'd4) % 32'd128;
    m_out.pc   = m_pc;
    m_out.res  = r;
    m_out.wbv  = wr;
    if (wr) m_out.wba = 5'(dst);
    m_out.ovf  = ovf;
    m_out.zero = (r == 32'd0);
    exp_q.push_back(m_out);
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)
      return {6'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              FN_LIST[$urandom_range(0, 12)]};
    else if (sel < 9)
      return {IOP_LIST[$urandom_range(0, 3)], 26'($urandom())};
    else
      return $urandom();
  endfunction

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    reset      = 1'b0;
    imem_we    = we;
    imem_waddr = addr;
    imem_wdata = data;
    model_step(we, addr, data);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"},   pc, 32'd0);
    chk({tag, "_res"},  alu_result, 32'd0);
    chk({tag, "_wbv"},  {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wba"},  {27'd0, wb_addr}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, overflow}, 32'd0);
    chk({tag, "_zero"}, {31'd0, zero}, 32'd1);
  endtask

  // Asynchronous reset in the middle of the low clock phase; outputs must
  // clear before the next rising edge.
  task automatic mid_reset();
    @(negedge clock);
    #2;
    imem_we = 1'b0;
    reset   = 1'b1;
    #1;
    check_reset("midrst");
    model_reset();
  endtask

  task automatic random_mix(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        drive(1'b1, 5'($urandom_range(0, 31)), rand_instr());
      else
        drive(1'b0, 5'd0, 32'd0);
    end
  endtask

  // Scoreboard monitor: every edge outside reset retires one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (!reset) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty required=entry (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pc",         pc, e.pc);
          chk("alu_result", alu_result, e.res);
          chk("wb_valid",   {31'd0, wb_valid}, {31'd0, e.wbv});
          chk("wb_addr",    {27'd0, wb_addr}, {27'd0, e.wba});
          chk("overflow",   {31'd0, overflow}, {31'd0, e.ovf});
          chk("zero",       {31'd0, zero}, {31'd0, e.zero});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_reset("por");

    prog[0] = 32'h0022_1820;  // add r3,r1,r2
    prog[1] = 32'h0045_2022;  // sub r4,r2,r5
    prog[2] = 32'h0001_3FC0;  // sll r7,r1,31
    prog[3] = 32'h00E7_4020;  // add r8,r7,r7 (overflow)
    prog[4] = 32'h0100_4825;  // or  r9,r8,r0
    prog[5] = 32'h0022_0020;  // add r0,r1,r2
    prog[6] = 32'h0000_5025;  // or  r10,r0,r0
    prog[7] = 32'h0000_003F;  // unknown funct
    prog[8] = 32'h2022_FFFF;  // addi r2,r1,-1
    prog[9] = 32'h7FFF_0000 | 32'h0000_0020;  // unknown opcode
    for (int i = 10; i < 32; i++) prog[i] = rand_instr();

    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), prog[i]);
    repeat (33) drive(1'b0, 5'd0, 32'd0);   // full pass plus wrap
    random_mix(40);
    mid_reset();
    repeat (40) drive(1'b0, 5'd0, 32'd0);
    mid_reset();
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), rand_instr());
    random_mix(200);

    @(negedge clock);
    imem_we = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
